note_slot_allocator: RTL

- Upstream companion to the arpeggiator. Converts a serial stream of note-on/note-off events into eight parallel held-key lines, key_on[7:0], plus the note number held in each slot.
- key_on[i] drives arpeggiator input key<i> directly. A new note fills the lowest free slot, so the arpeggiator steps notes in slot order.
- Sits between the MIDI/keyboard event decoder and the arpeggiator/voice bank.

---
 rtl/note_slot_allocator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/note_slot_allocator.sv
// Serial note-on/off events to eight parallel held-key slots for the arpeggiator.
// Each event scans all slots (one per cycle), then commits in a single cycle.
module note_slot_cmp #(
   parameter int NOTE_W = 7
) (
   input  logic              held,
   input  logic [NOTE_W-1:0] note,
   input  logic [NOTE_W-1:0] probe,
   output logic              hit
);
   assign hit = held && (note == probe);
endmodule

module note_slot_allocator #(
   parameter int NOTE_W    = 7,
   parameter int NUM_SLOTS = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          ev_valid,
   output logic                          ev_ready,
   input  logic                          ev_on,
   input  logic [NOTE_W-1:0]             ev_note,
   input  logic                          all_off,
   output logic [NUM_SLOTS-1:0]          key_on,
   output logic [NUM_SLOTS*NOTE_W-1:0]   slot_notes,
   output logic [3:0]                    active_count,
   output logic                          overflow
);
   localparam int IW = 3;
   localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t                              state;
   logic [IW-1:0]                       idx, match_idx, free_idx;
   logic                                lat_on, match_f, free_f;
   logic [NOTE_W-1:0]                   lat_note;
   logic [NUM_SLOTS-1:0][NOTE_W-1:0]    slots, slots_nxt;
   logic [NUM_SLOTS-1:0]                hit, key_nxt;
   logic [3:0]                          cnt_nxt;
   logic                                ovf_nxt;

   assign slot_notes = slots;
   assign ev_ready   = (state == IDLE) && !RESET;

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      note_slot_cmp #(.NOTE_W(NOTE_W)) u_cmp (
         .held  (key_on[g]),
         .note  (slots[g]),
         .probe (lat_note),
         .hit   (hit[g])
      );
   end

   // Commit result from the scan flags; duplicates and unmatched offs fall through unchanged.
   always_comb begin
      key_nxt   = key_on;
      slots_nxt = slots;
      ovf_nxt   = 1'b0;
      if (lat_on) begin
         if (!match_f) begin
            if (free_f) begin
               key_nxt[free_idx]   = 1'b1;
               slots_nxt[free_idx] = lat_note;
            end else begin
               ovf_nxt = 1'b1;
            end
         end
      end else if (match_f) begin
         key_nxt[match_idx]   = 1'b0;
         slots_nxt[match_idx] = '0;
      end
      cnt_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         cnt_nxt = cnt_nxt + {3'b000, key_nxt[i]};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         idx          <= '0;
         match_idx    <= '0;
         free_idx     <= '0;
         match_f      <= 1'b0;
         free_f       <= 1'b0;
         lat_on       <= 1'b0;
         lat_note     <= '0;
         key_on       <= '0;
         slots        <= '0;
         active_count <= '0;
         overflow     <= 1'b0;
      end else if (all_off) begin
         state        <= IDLE;
         idx          <= '0;
         key_on       <= '0;
         slots        <= '0;
         active_count <= '0;
         overflow     <= 1'b0;
      end else begin
         overflow <= 1'b0;
         case (state)
            IDLE: if (ev_valid && ev_ready) begin
               lat_on   <= ev_on;
               lat_note <= ev_note;
               match_f  <= 1'b0;
               free_f   <= 1'b0;
               idx      <= '0;
               state    <= SCAN;
            end
            SCAN: begin
               if (hit[idx] && !match_f) begin
                  match_f   <= 1'b1;
                  match_idx <= idx;
               end
               if (!key_on[idx] && !free_f) begin
                  free_f   <= 1'b1;
                  free_idx <= idx;
               end
               idx <= idx + 1'b1;
               if (idx == LAST) state <= COMMIT;
            end
            COMMIT: begin
               key_on       <= key_nxt;
               slots        <= slots_nxt;
               active_count <= cnt_nxt;
               overflow     <= ovf_nxt;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
